// File: rtl/eth_rx_slot_ctl.sv
// rtl/eth_rx_slot_ctl.sv - RMII frame admission and capture-ring slot scheduler (clk50 domain).
// Optional per-frame truncation at MAX_BYTES with out_trunc_o is enabled by defining ETH_SLOT_TRUNC_EN.
module eth_rx_slot_ctl #(
  parameter int SLOT_BITS = 10,
  parameter int MAX_BYTES = 1536
) (
  input  logic                 clk50,
  input  logic                 reset,
  input  logic                 enable_i,
  input  logic                 rxsop_i,
  input  logic                 rxeop_i,
  input  logic                 rxvalid_i,
  input  logic [7:0]           rxdata_i,
  input  logic                 release_i,
  output logic                 out_sop_o,
  output logic                 out_eop_o,
  output logic                 out_valid_o,
  output logic                 out_abort_o,
  output logic [7:0]           out_data_o,
  output logic [SLOT_BITS-1:0] slot_o,
  output logic [SLOT_BITS:0]   used_o,
  output logic                 full_o,
  output logic [15:0]          drop_count_o,
  output logic [31:0]          pkt_count_o
`ifdef ETH_SLOT_TRUNC_EN
  ,
  output logic                 out_trunc_o
`endif
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PASS = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

  localparam logic [SLOT_BITS:0] DEPTH = {1'b1, {SLOT_BITS{1'b0}}};

  if (MAX_BYTES < 1 || MAX_BYTES > 4095) begin : g_bad_max_bytes
    $error("MAX_BYTES must fit the 12-bit byte counter");
  end

  logic [1:0]           state_q, state_d;
  logic [SLOT_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [SLOT_BITS-1:0] slot_q, slot_d;
  logic [SLOT_BITS:0]   used_q, used_d;
  logic [15:0]          drop_q, drop_d;
  logic [31:0]          pkt_q, pkt_d;
  logic                 sop_q, sop_d;
  logic                 eop_q, eop_d;
  logic                 valid_q, valid_d;
  logic                 abort_q, abort_d;
  logic [7:0]           data_q, data_d;
  logic                 commit;
  logic                 drop_inc;
  logic                 fwd;
  logic                 rel_ok;

`ifdef ETH_SLOT_TRUNC_EN
  logic [11:0] byte_cnt_q, byte_cnt_d;
  logic        trunc_q, trunc_d;
  logic        out_trunc_q, out_trunc_d;
  logic        fwd_ok;
`endif

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    slot_d   = slot_q;
    sop_d    = 1'b0;
    eop_d    = 1'b0;
    abort_d  = 1'b0;
    commit   = 1'b0;
    drop_inc = 1'b0;
    fwd      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rxsop_i) begin
          if (enable_i && (used_q < DEPTH)) begin
            state_d = ST_PASS;
            sop_d   = 1'b1;
            slot_d  = wr_ptr_q;
          end else begin
            state_d  = ST_DROP;
            drop_inc = 1'b1;
          end
        end
      end
      ST_PASS: begin
        // rxeop wins over a same-cycle rxsop; that rxsop is simply discarded.
        if (rxeop_i) begin
          state_d  = ST_IDLE;
          commit   = 1'b1;
          eop_d    = 1'b1;
          fwd      = rxvalid_i;
          wr_ptr_d = wr_ptr_q + 1'b1;
        end else if (rxsop_i) begin
          state_d  = ST_IDLE;
          abort_d  = 1'b1;
          drop_inc = 1'b1;
        end else begin
          fwd = rxvalid_i;
        end
      end
      ST_DROP: begin
        if (rxeop_i) begin
          state_d = ST_IDLE;
        end else if (rxsop_i) begin
          drop_inc = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef ETH_SLOT_TRUNC_EN
  always_comb begin
    fwd_ok      = fwd && (byte_cnt_q < 12'(MAX_BYTES));
    byte_cnt_d  = byte_cnt_q;
    trunc_d     = trunc_q;
    if (sop_d) begin
      byte_cnt_d = 12'd0;
      trunc_d    = 1'b0;
    end else if (fwd_ok) begin
      byte_cnt_d = byte_cnt_q + 12'd1;
    end else if (fwd) begin
      trunc_d = 1'b1;
    end
    out_trunc_d = commit && (trunc_q || (fwd && !fwd_ok));
    valid_d     = fwd_ok;
    data_d      = fwd_ok ? rxdata_i : 8'h00;
  end
`else
  always_comb begin
    valid_d = fwd;
    data_d  = fwd ? rxdata_i : 8'h00;
  end
`endif

  always_comb begin
    rel_ok = release_i && (used_q != '0);
    used_d = used_q;
    case ({commit, rel_ok})
      2'b10:   used_d = used_q + 1'b1;
      2'b01:   used_d = used_q - 1'b1;
      default: used_d = used_q;
    endcase
    pkt_d  = pkt_q + {31'd0, commit};
    drop_d = (drop_inc && (drop_q != 16'hFFFF)) ? drop_q + 16'd1 : drop_q;
  end

  always_ff @(posedge clk50) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      slot_q   <= '0;
      used_q   <= '0;
      drop_q   <= 16'd0;
      pkt_q    <= 32'd0;
      sop_q    <= 1'b0;
      eop_q    <= 1'b0;
      valid_q  <= 1'b0;
      abort_q  <= 1'b0;
      data_q   <= 8'h00;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      slot_q   <= slot_d;
      used_q   <= used_d;
      drop_q   <= drop_d;
      pkt_q    <= pkt_d;
      sop_q    <= sop_d;
      eop_q    <= eop_d;
      valid_q  <= valid_d;
      abort_q  <= abort_d;
      data_q   <= data_d;
    end
  end

`ifdef ETH_SLOT_TRUNC_EN
  always_ff @(posedge clk50) begin
    if (reset) begin
      byte_cnt_q  <= 12'd0;
      trunc_q     <= 1'b0;
      out_trunc_q <= 1'b0;
    end else begin
      byte_cnt_q  <= byte_cnt_d;
      trunc_q     <= trunc_d;
      out_trunc_q <= out_trunc_d;
    end
  end

  assign out_trunc_o = out_trunc_q;
`endif

  assign out_sop_o    = sop_q;
  assign out_eop_o    = eop_q;
  assign out_valid_o  = valid_q;
  assign out_abort_o  = abort_q;
  assign out_data_o   = data_q;
  assign slot_o       = slot_q;
  assign used_o       = used_q;
  assign full_o       = (used_q == DEPTH);
  assign drop_count_o = drop_q;
  assign pkt_count_o  = pkt_q;

endmodule

// File: tb/tb_eth_rx_slot_ctl.sv
// tb/tb_eth_rx_slot_ctl.sv - table-driven and sequence checks for eth_rx_slot_ctl at DEPTH=4.
module tb_eth_rx_slot_ctl;

  localparam int SB = 2;
  localparam int MB = 100;

  logic          clk50 = 1'b0;
  logic          reset, enable, rxsop, rxeop, rxvalid, rel;
  logic [7:0]    rxdata;
  logic          out_sop, out_eop, out_valid, out_abort;
  logic [7:0]    out_data;
  logic [SB-1:0] slot;
  logic [SB:0]   used;
  logic          full;
  logic [15:0]   drop_count;
  logic [31:0]   pkt_count;
`ifdef ETH_SLOT_TRUNC_EN
  logic          out_trunc;
`endif

  always #10 clk50 = ~clk50;

  eth_rx_slot_ctl #(.SLOT_BITS(SB), .MAX_BYTES(MB)) dut (
    .clk50(clk50), .reset(reset), .enable_i(enable),
    .rxsop_i(rxsop), .rxeop_i(rxeop), .rxvalid_i(rxvalid), .rxdata_i(rxdata),
    .release_i(rel),
    .out_sop_o(out_sop), .out_eop_o(out_eop), .out_valid_o(out_valid),
    .out_abort_o(out_abort), .out_data_o(out_data),
    .slot_o(slot), .used_o(used), .full_o(full),
    .drop_count_o(drop_count), .pkt_count_o(pkt_count)
`ifdef ETH_SLOT_TRUNC_EN
    , .out_trunc_o(out_trunc)
`endif
  );

  int nvec = 0;
  int nbad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk50);
    #1;
  endtask

  task automatic clear_in();
    rxsop = 1'b0; rxeop = 1'b0; rxvalid = 1'b0; rxdata = 8'h00; rel = 1'b0;
  endtask

  task automatic do_reset();
    clear_in();
    enable = 1'b1;
    reset  = 1'b1;
    step();
    reset  = 1'b0;
  endtask

  // Sends sop then n bytes (eop on the last byte) and tallies what came out.
  task automatic run_frame(input int n, input int en_low_at, input bit rel_last,
                           output int got_sop, output int got_slot, output int nvld,
                           output int nerr, output int neop, output int ntrunc);
    logic [7:0] exp_b;
    nvld = 0; nerr = 0; neop = 0; ntrunc = 0;
    rxsop = 1'b1;
    step();
    got_sop  = int'(out_sop);
    got_slot = int'(slot);
    rxsop = 1'b0;
    for (int i = 0; i < n; i++) begin
      exp_b   = 8'(i * 7 + 3);
      rxvalid = 1'b1;
      rxdata  = exp_b;
      rxeop   = (i == n - 1);
      rel     = rel_last && (i == n - 1);
      if (i == en_low_at) enable = 1'b0;
      step();
      if (out_valid) begin
        nvld++;
        if (out_data !== exp_b) nerr++;
      end
      if (out_sop) nerr++;
      if (out_eop) neop++;
`ifdef ETH_SLOT_TRUNC_EN
      if (out_eop && out_trunc) ntrunc++;
`endif
    end
    clear_in();
  endtask

  typedef struct {
    logic       rst, en, sop, eop, vld;
    logic [7:0] d;
    logic       rl;
    logic       e_sop, e_eop, e_vld, e_abt;
    logic [7:0] e_d;
    logic [1:0] e_slot;
    logic [2:0] e_used;
    logic [15:0] e_drop;
    logic [31:0] e_pkt;
  } vec_t;

  vec_t tbl[17];

  initial begin
    int gs, gl, nv, ne, neo, ntr;

    //           rst   en    sop   eop   vld   data   rel    sop   eop   vld   abt   data   slot  used  drop    pkt
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0,  1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 3'd0, 16'd0, 32'd0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0,  1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 3'd0, 16'd0, 32'd0};
    tbl[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0,  1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 3'd0, 16'd0, 32'd0};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0,  1'b0, 1'b0, 1'b1, 1'b0, 8'hA5, 2'd0, 3'd0, 16'd0, 32'd0};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b0,  1'b0, 1'b0, 1'b1, 1'b0, 8'h3C, 2'd0, 3'd0, 16'd0, 32'd0};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h7E, 1'b0,  1'b0, 1'b1, 1'b1, 1'b0, 8'h7E, 2'd0, 3'd1, 16'd0, 32'd1};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1,  1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 3'd0, 16'd0, 32'd1};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1,  1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 3'd0, 16'd0, 32'd1};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0,  1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 3'd0, 16'd1, 32'd1};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0,  1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 3'd0, 16'd2, 32'd1};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h55, 1'b0,  1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 3'd0, 16'd2, 32'd1};
    tbl[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0,  1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 2'd1, 3'd0, 16'd2, 32'd1};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h11, 1'b0,  1'b0, 1'b0, 1'b1, 1'b0, 8'h11, 2'd1, 3'd0, 16'd2, 32'd1};
    tbl[13] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0,  1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 2'd1, 3'd0, 16'd3, 32'd1};
    tbl[14] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0,  1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 2'd1, 3'd0, 16'd3, 32'd1};
    tbl[15] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0,  1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 2'd1, 3'd1, 16'd3, 32'd2};
    tbl[16] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0,  1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 2'd1, 3'd1, 16'd3, 32'd2};

    clear_in();
    enable = 1'b0;
    reset  = 1'b1;
    step();

    for (int i = 0; i < 17; i++) begin
      reset = tbl[i].rst; enable = tbl[i].en; rxsop = tbl[i].sop; rxeop = tbl[i].eop;
      rxvalid = tbl[i].vld; rxdata = tbl[i].d; rel = tbl[i].rl;
      step();
      chk($sformatf("v%0d.sop", i),   32'(out_sop),    32'(tbl[i].e_sop));
      chk($sformatf("v%0d.eop", i),   32'(out_eop),    32'(tbl[i].e_eop));
      chk($sformatf("v%0d.vld", i),   32'(out_valid),  32'(tbl[i].e_vld));
      chk($sformatf("v%0d.abt", i),   32'(out_abort),  32'(tbl[i].e_abt));
      chk($sformatf("v%0d.data", i),  32'(out_data),   32'(tbl[i].e_d));
      chk($sformatf("v%0d.slot", i),  32'(slot),       32'(tbl[i].e_slot));
      chk($sformatf("v%0d.used", i),  32'(used),       32'(tbl[i].e_used));
      chk($sformatf("v%0d.full", i),  32'(full),       32'(tbl[i].e_used == 3'd4));
      chk($sformatf("v%0d.drop", i),  32'(drop_count), 32'(tbl[i].e_drop));
      chk($sformatf("v%0d.pkt", i),   pkt_count,       tbl[i].e_pkt);
    end
    clear_in();

    // 64-byte frame after reset
    do_reset();
    run_frame(64, -1, 1'b0, gs, gl, nv, ne, neo, ntr);
    chk("f64.sop", 32'(gs), 32'd1);
    chk("f64.slot", 32'(gl), 32'd0);
    chk("f64.nvalid", 32'(nv), 32'd64);
    chk("f64.dataerr", 32'(ne), 32'd0);
    chk("f64.eop", 32'(neo), 32'd1);
    chk("f64.used", 32'(used), 32'd1);
    chk("f64.pkt", pkt_count, 32'd1);

    // fill the ring, overflow, release, refill slot 0
    do_reset();
    for (int k = 0; k < 4; k++) begin
      run_frame(3, -1, 1'b0, gs, gl, nv, ne, neo, ntr);
      chk($sformatf("fill%0d.sop", k), 32'(gs), 32'd1);
      chk($sformatf("fill%0d.slot", k), 32'(gl), 32'(k));
    end
    chk("fill.full", 32'(full), 32'd1);
    chk("fill.used", 32'(used), 32'd4);
    run_frame(3, -1, 1'b0, gs, gl, nv, ne, neo, ntr);
    chk("over.sop", 32'(gs), 32'd0);
    chk("over.nvalid", 32'(nv), 32'd0);
    chk("over.eop", 32'(neo), 32'd0);
    chk("over.drop", 32'(drop_count), 32'd1);
    chk("over.used", 32'(used), 32'd4);
    rel = 1'b1;
    step();
    rel = 1'b0;
    chk("rel.used", 32'(used), 32'd3);
    chk("rel.full", 32'(full), 32'd0);
    run_frame(3, -1, 1'b0, gs, gl, nv, ne, neo, ntr);
    chk("refill.sop", 32'(gs), 32'd1);
    chk("refill.slot", 32'(gl), 32'd0);
    chk("refill.used", 32'(used), 32'd4);
    chk("refill.pkt", pkt_count, 32'd5);

    // commit and release in the same cycle
    do_reset();
    run_frame(2, -1, 1'b0, gs, gl, nv, ne, neo, ntr);
    run_frame(2, -1, 1'b0, gs, gl, nv, ne, neo, ntr);
    run_frame(2, -1, 1'b1, gs, gl, nv, ne, neo, ntr);
    chk("relcommit.used", 32'(used), 32'd2);
    chk("relcommit.pkt", pkt_count, 32'd3);

    // release at used=0
    do_reset();
    rel = 1'b1;
    step();
    rel = 1'b0;
    chk("rel0.used", 32'(used), 32'd0);

    // enable dropped mid-frame
    do_reset();
    run_frame(60, 10, 1'b0, gs, gl, nv, ne, neo, ntr);
    chk("enmid.nvalid", 32'(nv), 32'd60);
    chk("enmid.dataerr", 32'(ne), 32'd0);
    chk("enmid.eop", 32'(neo), 32'd1);
    chk("enmid.pkt", pkt_count, 32'd1);
    run_frame(5, -1, 1'b0, gs, gl, nv, ne, neo, ntr);
    chk("enoff.sop", 32'(gs), 32'd0);
    chk("enoff.nvalid", 32'(nv), 32'd0);
    chk("enoff.drop", 32'(drop_count), 32'd1);
    enable = 1'b1;

    // reset mid-frame loses the frame silently
    do_reset();
    rxsop = 1'b1;
    step();
    rxsop = 1'b0; rxvalid = 1'b1; rxdata = 8'h42;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0; rxeop = 1'b1;
    step();
    chk("rstmid.eop", 32'(out_eop), 32'd0);
    chk("rstmid.abort", 32'(out_abort), 32'd0);
    chk("rstmid.valid", 32'(out_valid), 32'd0);
    chk("rstmid.pkt", pkt_count, 32'd0);
    chk("rstmid.used", 32'(used), 32'd0);
    clear_in();

`ifdef ETH_SLOT_TRUNC_EN
    do_reset();
    run_frame(150, -1, 1'b0, gs, gl, nv, ne, neo, ntr);
    chk("trunc.nvalid", 32'(nv), 32'd100);
    chk("trunc.dataerr", 32'(ne), 32'd0);
    chk("trunc.eop", 32'(neo), 32'd1);
    chk("trunc.flag", 32'(ntr), 32'd1);
    chk("trunc.pkt", pkt_count, 32'd1);
    run_frame(50, -1, 1'b0, gs, gl, nv, ne, neo, ntr);
    chk("notrunc.nvalid", 32'(nv), 32'd50);
    chk("notrunc.flag", 32'(ntr), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule

// File: doc/eth_rx_slot_ctl.md
# eth_rx_slot_ctl

Admission and slot-scheduling controller in the clk50 domain between the RMII receiver and the packet capture/DMA path. Each received frame either gets the next free capture-ring slot or is dropped whole, gated by a software enable and the number of slots not yet released. The byte stream is forwarded with one cycle of latency, with the assigned slot index and status counters. The block also detects aborted frames, where a new SOP arrives before EOP.

## Interface
- SLOT_BITS, 10, log2 of ring depth; DEPTH = 2^SLOT_BITS slots
- MAX_BYTES, 1536, per-frame byte limit (used only with ETH_SLOT_TRUNC_EN)
- clk50  in  1  RMII-domain clock
- reset  in  1  reset, synchronous, active-high; clock clk50
- enable  in  1  capture enable, already synchronized to clk50
- rxsop, rxeop, rxvalid  in  1 each  frame strobes from the RMII receiver
- rxdata  in  8  received byte, qualified by rxvalid
- release  in  1  one-cycle pulse: software has consumed the oldest committed slot
- out_sop, out_eop, out_valid, out_abort  out  1 each  gated stream strobes
- out_data  out  8  forwarded byte
- slot  out  SLOT_BITS  slot index of the current accepted frame
- used  out  SLOT_BITS+1  committed, unreleased slot count
- full  out  1  used == DEPTH
- drop_count  out  16  frames refused, saturating at 16'hFFFF
- pkt_count  out  32  frames committed, wrapping

## Operation
- Frame-level state machine.
  - IDLE: on rxsop, go to PASS when enable=1 and used < DEPTH. Otherwise go to DROP and increment drop_count.
  - PASS: forward bytes. On rxeop, commit and go to IDLE. On rxsop with no rxeop, abort and go to IDLE.
  - DROP: discard bytes. On rxeop, go to IDLE. On rxsop, stay in DROP and count one more drop.
- Accept in IDLE: pulse out_sop and load slot <= wr_ptr.
- Forwarding in PASS: each rxvalid byte produces out_valid=1 with out_data=rxdata.
- Commit on rxeop in PASS:
  - pulse out_eop;
  - wr_ptr <= wr_ptr+1, wrapping mod DEPTH;
  - used increments;
  - pkt_count increments.
- Abort on rxsop in PASS:
  - pulse out_abort, with no out_eop and no commit; wr_ptr is unchanged, so the slot is reused;
  - the new frame is dropped and counted in drop_count.
- rxsop and rxeop in the same cycle in PASS: rxeop wins. The frame commits, and the rxsop is evaluated by IDLE rules on the following cycle only if it is re-asserted. A same-cycle rxsop is ignored.
- release:
  - When used > 0, decrement used.
  - When used == 0, ignore it.
  - Commit and release in the same cycle: used is unchanged.
- enable deasserted mid-frame: the current frame completes normally and only later frames are refused. enable low at rxsop: drop.
- full is combinational from registered used, so it carries no extra latency.
- Counter arithmetic: drop_count saturates at 16'hFFFF; pkt_count wraps 2^32-1 -> 0; used never exceeds DEPTH.

## Timing
- Reset values: all out_* = 0, slot = 0, used = 0, full = 0, drop_count = 0, pkt_count = 0, wr_ptr = 0, state IDLE.
- Reset mid-frame: no out_eop or out_abort is emitted, and the frame is lost.
- All outputs are registered.
  - rx strobe or byte at cycle N: out_* at cycle N+1.
  - used, pkt_count, drop_count update at N+1 of the causing event.
- slot becomes valid in the same cycle as out_sop and holds until the next out_sop.
- out_sop, out_eop and out_abort are single-cycle pulses. out_sop and out_valid never coincide.
- There is no back-pressure. The downstream writer must accept one byte per clk50 cycle.

## Configuration
- ETH_SLOT_TRUNC_EN defined:
  - A 12-bit byte counter runs in PASS.
  - Bytes after the MAX_BYTES-th are not forwarded. The frame still commits on rxeop.
  - out_eop is accompanied by out_trunc=1 (an extra 1-bit output, present only with the macro) when any byte was discarded.
- Undefined: no byte counter and no out_trunc port; frames of any length are forwarded intact.

## Test plan
- Reset, enable=1, one 64-byte frame -> out_sop with slot=0; 64 out_valid matching rxdata, each one cycle late; out_eop; used=1, pkt_count=1.
- DEPTH=4 (SLOT_BITS=2), 5 frames with no release -> slots 0,1,2,3 accepted; 5th dropped; full=1; drop_count=1. One release, then a 6th frame -> accepted with slot=0.
- rxsop mid-frame in PASS -> out_abort and no out_eop; drop_count+1. Next good frame reuses the same slot; used unchanged by the abort.
- release in the same cycle as commit with used=2 -> used stays 2. release at used=0 -> used stays 0.
- enable dropped at byte 10 of a 60-byte frame -> full frame forwarded and committed; next frame dropped, drop_count=1.
- With ETH_SLOT_TRUNC_EN, MAX_BYTES=100, 150-byte frame -> 100 out_valid; out_eop with out_trunc=1; pkt_count+1.
